// File: rtl/burst_arbiter.sv
`timescale 1ns/1ps
// Burst-limited round-robin arbiter for two pipelines sharing one resource port.
// Owns the request mux, a single registered output stage and per-requester grant counters.
//
//   state (last_2, run) | meaning
//   last_2 = 0          | requester 1 was granted most recently
//   last_2 = 1          | requester 2 was granted most recently
//   run                 | consecutive grants to last, saturating at MAX_BURST
module burst_arbiter #(
  parameter int MAX_BURST     = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] in_address_1,
  input  logic [ID_WIDTH-1:0]      in_id_1,
  input  logic                     in_valid_1,
  output logic                     out_stall_1,
  input  logic [ADDRESS_WIDTH-1:0] in_address_2,
  input  logic [ID_WIDTH-1:0]      in_id_2,
  input  logic                     in_valid_2,
  output logic                     out_stall_2,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  output logic [15:0]              out_grant_count_1,
  output logic [15:0]              out_grant_count_2
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_BURST);

  logic       last_2, last_2_nxt;
  logic [3:0] run, run_nxt;
  logic       accept;
  logic       grant_1, grant_2;

  assign accept = !(out_valid && in_stall);

  // State register, output stage and counters all load on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_2            <= 1'b0;
      run               <= 4'd0;
      out_valid         <= 1'b0;
      out_address       <= '0;
      out_id            <= '0;
      out_grant_count_1 <= 16'd0;
      out_grant_count_2 <= 16'd0;
    end else begin
      last_2 <= last_2_nxt;
      run    <= run_nxt;
      if (accept) begin
        out_valid <= grant_1 || grant_2;
        if (grant_1) begin
          out_address <= in_address_1;
          out_id      <= in_id_1;
        end else if (grant_2) begin
          out_address <= in_address_2;
          out_id      <= in_id_2;
        end
      end
      if (grant_1) out_grant_count_1 <= out_grant_count_1 + 16'd1;
      if (grant_2) out_grant_count_2 <= out_grant_count_2 + 16'd1;
    end
  end

  // Winner selection and next priority state.
  always_comb begin
    grant_1    = 1'b0;
    grant_2    = 1'b0;
    last_2_nxt = last_2;
    run_nxt    = run;
    if (accept && !reset) begin
      if (in_valid_1 && in_valid_2) begin
        if ((run < MAX_RUN) ? !last_2 : last_2) grant_1 = 1'b1;
        else                                    grant_2 = 1'b1;
      end else begin
        grant_1 = in_valid_1;
        grant_2 = in_valid_2;
      end
    end
    if (grant_1 || grant_2) begin
      if (grant_2 == last_2) begin
        run_nxt = (run == MAX_RUN) ? run : run + 4'd1;
      end else begin
        last_2_nxt = grant_2;
        run_nxt    = 4'd1;
      end
    end
  end

  // Stalls depend only on valids, backpressure and registered state.
  always_comb begin
    out_stall_1 = reset || (in_valid_1 && !grant_1);
    out_stall_2 = reset || (in_valid_2 && !grant_2);
  end

endmodule
